// File: rtl/jk_counter_pkg.sv
// Shared constants for the JK-flip-flop based counter family.
// JK op codes are encoded as {j, k}.
package jk_counter_pkg;

   localparam logic [1:0] JK_HOLD = 2'b00;
   localparam logic [1:0] JK_CLR  = 2'b01;
   localparam logic [1:0] JK_SET  = 2'b10;
   localparam logic [1:0] JK_TOG  = 2'b11;

   localparam int JK_CNT_WIDTH = 3;

endpackage

// File: rtl/jk_ff.sv
// Single JK flip-flop with synchronous active-high reset to 0.
module jk_ff (
   input  logic clk,
   input  logic reset,
   input  logic j,
   input  logic k,
   output logic q
);
   import jk_counter_pkg::*;

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            JK_HOLD: q <= q;
            JK_CLR:  q <= 1'b0;
            JK_SET:  q <= 1'b1;
            JK_TOG:  q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-N up/down counter built from per-bit JK flip-flops, with load, tc and wrap.
// Define JK_COUNTER_SATURATE_EN to saturate at the range ends instead of wrapping.
module jk_updown_counter
   import jk_counter_pkg::*;
#(
   parameter int WIDTH   = JK_CNT_WIDTH,
   parameter int MODULUS = (1 << WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] stepQ;
   logic [WIDTH-1:0] loadQ;
   logic [WIDTH-1:0] jVec;
   logic [WIDTH-1:0] kVec;
   logic             atMax;
   logic             atZero;
   logic             aboveMax;
   logic             wrapNext;

   // Out-of-range states are treated as if they sat just past the top boundary.
   always_comb begin
      atMax    = (Q == MAXV);
      atZero   = (Q == '0);
      aboveMax = (Q > MAXV);
      loadQ    = (load_val > MAXV) ? MAXV : load_val;
      stepQ    = Q;
      wrapNext = 1'b0;
`ifdef JK_COUNTER_SATURATE_EN
      if (up_dn) stepQ = (atMax || aboveMax) ? MAXV : Q + WIDTH'(1);
      else       stepQ = aboveMax ? MAXV : (atZero ? '0 : Q - WIDTH'(1));
`else
      if (up_dn) stepQ = (atMax || aboveMax) ? '0 : Q + WIDTH'(1);
      else       stepQ = (atZero || aboveMax) ? MAXV : Q - WIDTH'(1);
      wrapNext = en & ~load & (up_dn ? atMax : atZero);
`endif
      if (load) begin
         jVec = loadQ;
         kVec = ~loadQ;
      end else if (en) begin
         jVec = Q ^ stepQ;
         kVec = Q ^ stepQ;
      end else begin
         jVec = '0;
         kVec = '0;
      end
   end

   assign tc = en & ~reset & ~load & (up_dn ? atMax : atZero);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      jk_ff u_ff (
         .clk   (clk),
         .reset (reset),
         .j     (jVec[i]),
         .k     (kVec[i]),
         .q     (Q[i])
      );
   end

   // Wrap pulse lines up with the first cycle showing the post-wrap value.
   always_ff @(posedge clk) begin
      if (reset) wrap <= 1'b0;
      else       wrap <= wrapNext;
   end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench: directed scenarios plus random traffic against a modulo-arithmetic model,
// on a WIDTH=3/MODULUS=6 counter and a WIDTH=4/MODULUS=16 counter.
module tb_jk_updown_counter;

   localparam int M1 = 6;
   localparam int M2 = 16;

   logic       clk;
   logic       reset, en, up_dn, load;
   logic [2:0] load_val;
   logic [2:0] Q;
   logic       tc, wrap;

   logic       reset16, en16, up_dn16, load16;
   logic [3:0] load_val16;
   logic [3:0] Q16;
   logic       tc16, wrap16;

   int evaluated = 0;
   int failures  = 0;
   int modelQ    = 0;
   int modelWrap = 0;
   int modelQ16  = 0;
   int modelWrap16 = 0;

   jk_updown_counter #(.WIDTH(3), .MODULUS(M1)) dut (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .Q(Q), .tc(tc), .wrap(wrap)
   );

   jk_updown_counter #(.WIDTH(4), .MODULUS(M2)) dut16 (
      .clk(clk), .reset(reset16), .en(en16), .up_dn(up_dn16), .load(load16),
      .load_val(load_val16), .Q(Q16), .tc(tc16), .wrap(wrap16)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int nextCount(int q, int m, bit up);
`ifdef JK_COUNTER_SATURATE_EN
      if (up) return (q + 1 > m - 1) ? m - 1 : q + 1;
      else    return (q - 1 < 0) ? 0 : q - 1;
`else
      if (up) return (q + 1) % m;
      else    return (q - 1 + m) % m;
`endif
   endfunction

   function automatic int crosses(int q, int m, bit up);
`ifdef JK_COUNTER_SATURATE_EN
      return 0;
`else
      if (up) return (q + 1 >= m) ? 1 : 0;
      else    return (q - 1 < 0) ? 1 : 0;
`endif
   endfunction

   function automatic int boundary(int q, int m, bit up);
      if (up) return (q == m - 1) ? 1 : 0;
      else    return (q == 0) ? 1 : 0;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      evaluated++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit ld, input int lv, input bit e, input bit ud);
      int expTc;
      reset = rst; load = ld; load_val = 3'(lv); en = e; up_dn = ud;
      #1;
      expTc = (e && !rst && !ld) ? boundary(modelQ, M1, ud) : 0;
      checkOutput("tc", 32'(tc), 32'(expTc));
      @(posedge clk);
      #1;
      if (rst) begin
         modelQ = 0; modelWrap = 0;
      end else if (ld) begin
         modelQ = (lv > M1 - 1) ? M1 - 1 : lv; modelWrap = 0;
      end else if (e) begin
         modelWrap = crosses(modelQ, M1, ud);
         modelQ    = nextCount(modelQ, M1, ud);
      end else begin
         modelWrap = 0;
      end
      checkOutput("Q", 32'(Q), 32'(modelQ));
      checkOutput("wrap", 32'(wrap), 32'(modelWrap));
   endtask

   task automatic applyWide(input bit e, input bit ud);
      int expTc;
      en16 = e; up_dn16 = ud;
      #1;
      expTc = e ? boundary(modelQ16, M2, ud) : 0;
      checkOutput("tc16", 32'(tc16), 32'(expTc));
      @(posedge clk);
      #1;
      if (e) begin
         modelWrap16 = crosses(modelQ16, M2, ud);
         modelQ16    = nextCount(modelQ16, M2, ud);
      end else begin
         modelWrap16 = 0;
      end
      checkOutput("Q16", 32'(Q16), 32'(modelQ16));
      checkOutput("wrap16", 32'(wrap16), 32'(modelWrap16));
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
      reset16 = 1'b1; en16 = 1'b0; up_dn16 = 1'b1; load16 = 1'b0; load_val16 = '0;

      // Reset wins even with en asserted, then free-run up through the wrap.
      repeat (2) applyStimulus(1, 0, 0, 1, 1);
      repeat (8) applyStimulus(0, 0, 0, 1, 1);

      // Count down through zero from 1.
      applyStimulus(0, 1, 1, 0, 0);
      repeat (3) applyStimulus(0, 0, 0, 1, 0);

      // Loads: in range, clamped, exactly MODULUS, and load overriding en.
      applyStimulus(0, 1, 3, 1, 1);
      applyStimulus(0, 1, 7, 1, 0);
      applyStimulus(0, 1, 6, 0, 1);
      applyStimulus(0, 1, 2, 1, 1);
      applyStimulus(0, 1, 5, 1, 1);
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 1);

      // Hold, then reset beats load and en.
      applyStimulus(0, 1, 4, 0, 1);
      repeat (4) applyStimulus(0, 0, 0, 0, 1);
      applyStimulus(1, 1, 5, 1, 1);

      // Direction flip on consecutive edges.
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 1);
      applyStimulus(0, 0, 0, 1, 1);

      repeat (200) begin
         applyStimulus(($urandom_range(0, 19) == 0),
                       ($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) != 0),
                       1'($urandom_range(0, 1)));
      end

      // Wide counter: free run across the 15 -> 0 wrap, then a short down run.
      reset16 = 1'b0;
      modelQ16 = 0;
      repeat (20) applyWide(1, 1);
      repeat (6) applyWide(1, 0);
      applyWide(0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
      $finish;
   end

endmodule
